// File: rtl/test_status_ctrl.sv
// test_status_ctrl
// ----------------
// Memory-mapped test-status peripheral for SoC simulation and FPGA self-test.
// Software reports pass/fail events, requests completion and streams console
// characters through a small register block.  A cycle watchdog forces
// completion if software never finishes.
//
// Register map (byte offsets from BASE_ADDR, word-aligned, offset = addr[4:2]):
//   0x00 RESULT   W: wdata[1:0] 01 = pass++, 10 = fail++, 11 = finish, 00 = no-op
//                 R: {state, timeout, done} in bits [2:0]
//   0x04 PASS_CNT R
//   0x08 FAIL_CNT R
//   0x0C CYCLE    R: cycle counter, zero-extended or truncated to DATA_WIDTH
//   0x10 CONSOLE  W: wdata[7:0] emitted on char_data with a char_valid pulse
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bus_en, bus_we, bus_addr,
//   bus_wdata                     single-cycle access request
//   bus_rdata, bus_rvalid         registered read response
//   char_valid, char_data         registered console character strobe
//   done, passed, timeout         registered completion status
//
// Bus semantics: there is no handshake back-pressure.  An access is accepted
// in every cycle where bus_en is high and the address selects this block.
// A read returns bus_rvalid = 1 with its data in the following cycle only;
// bus_rdata is 0 whenever bus_rvalid is 0.  A write takes effect at the edge
// that samples it.  Unselected accesses produce no response at all; selected
// accesses to unmapped offsets complete and read as 0.

module test_status_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'hFFFF_FF00,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    CYC_WIDTH  = 32,
    parameter int unsigned           MAX_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_en,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_rvalid,
    output logic                  char_valid,
    output logic [7:0]            char_data,
    output logic                  done,
    output logic                  passed,
    output logic                  timeout
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] OFF_RESULT  = 3'd0;
    localparam logic [2:0] OFF_PASS    = 3'd1;
    localparam logic [2:0] OFF_FAIL    = 3'd2;
    localparam logic [2:0] OFF_CYCLE   = 3'd3;
    localparam logic [2:0] OFF_CONSOLE = 3'd4;

    localparam logic [1:0] CMD_PASS    = 2'b01;
    localparam logic [1:0] CMD_FAIL    = 2'b10;
    localparam logic [1:0] CMD_FINISH  = 2'b11;

    localparam bit                   WD_EN   = (MAX_CYCLES != 0);
    // Last cycle count value before expiry; unused when the watchdog is off.
    localparam logic [CYC_WIDTH-1:0] WD_LAST = CYC_WIDTH'(MAX_CYCLES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [CNT_WIDTH-1:0]   pass_cnt;
    logic [CNT_WIDTH-1:0]   fail_cnt;
    logic [CYC_WIDTH-1:0]   cycle_cnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                   sel;
    logic [2:0]             off;
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   running;

    assign sel     = bus_en && (bus_addr[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]);
    assign off     = bus_addr[4:2];
    assign wr_acc  = sel && bus_we;
    assign rd_acc  = sel && !bus_we;
    assign running = (state == ST_RUN);

    // Writes that change state are only honoured while running; in DONE
    // the RESULT and CONSOLE registers become inert.
    logic                   res_wr;
    logic                   con_wr;
    logic                   pass_inc;
    logic                   fail_inc;
    logic                   finish_req;

    assign res_wr     = wr_acc && (off == OFF_RESULT)  && running;
    assign con_wr     = wr_acc && (off == OFF_CONSOLE) && running;
    assign pass_inc   = res_wr && (bus_wdata[1:0] == CMD_PASS);
    assign fail_inc   = res_wr && (bus_wdata[1:0] == CMD_FAIL);
    assign finish_req = res_wr && (bus_wdata[1:0] == CMD_FINISH);

    // Watchdog fires on the last counted cycle of the budget.
    logic                   wd_hit;
    assign wd_hit = WD_EN && running && (cycle_cnt == WD_LAST);

    // ------------------------------------------------------------------
    // FSM: next state and completion events
    // ------------------------------------------------------------------
    logic                   enter_done;
    logic                   enter_timeout;

    always_comb begin
        state_nxt     = state;
        enter_done    = 1'b0;
        enter_timeout = 1'b0;
        case (state)
            ST_RUN: begin
                // A finish in the expiry cycle takes priority, so the run is
                // treated as completed by software rather than timed out.
                if (finish_req) begin
                    state_nxt  = ST_DONE;
                    enter_done = 1'b1;
                end else if (wd_hit) begin
                    state_nxt     = ST_DONE;
                    enter_done    = 1'b1;
                    enter_timeout = 1'b1;
                end
            end
            ST_DONE: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Counters (saturating)
    // ------------------------------------------------------------------
    logic                   cycle_adv;
    // The cycle count stops on the edge that leaves RUN, so after a
    // watchdog expiry it still shows the last counted cycle (MAX_CYCLES-1).
    assign cycle_adv = running && (state_nxt == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            cycle_cnt <= '0;
        end else begin
            if (pass_inc && (pass_cnt != '1)) begin
                pass_cnt <= pass_cnt + CNT_WIDTH'(1);
            end
            if (fail_inc && (fail_cnt != '1)) begin
                fail_cnt <= fail_cnt + CNT_WIDTH'(1);
            end
            if (cycle_adv && (cycle_cnt != '1)) begin
                cycle_cnt <= cycle_cnt + CYC_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Completion status
    // ------------------------------------------------------------------
    // Fail writes and the finish write are separate accesses, so fail_cnt
    // is already final when the finish is sampled; passed can be decided
    // from its current value.
    always_ff @(posedge clk) begin
        if (rst) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            passed  <= 1'b0;
        end else if (enter_done) begin
            done    <= 1'b1;
            timeout <= enter_timeout;
            passed  <= !enter_timeout && (fail_cnt == '0);
        end
    end

    // ------------------------------------------------------------------
    // Console
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            char_valid <= 1'b0;
            char_data  <= 8'h00;
        end else begin
            char_valid <= con_wr;
            if (con_wr) begin
                char_data <= bus_wdata[7:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]  rd_mux;

    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_RESULT: rd_mux[2:0] = {(state == ST_DONE), timeout, done};
            OFF_PASS:   rd_mux      = DATA_WIDTH'(pass_cnt);
            OFF_FAIL:   rd_mux      = DATA_WIDTH'(fail_cnt);
            OFF_CYCLE:  rd_mux      = DATA_WIDTH'(cycle_cnt);
            default:    rd_mux      = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            bus_rvalid <= rd_acc;
            bus_rdata  <= rd_acc ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_test_status_ctrl.sv
// Directed testbench for test_status_ctrl.  A default-parameter instance
// covers the register map, completion, watchdog and console behaviour; a
// second instance with 2-bit counters and the watchdog disabled covers
// counter saturation.  Both share clock and reset; a select bit steers the
// single driven bus to one of them.

module tb_test_status_ctrl;

    localparam logic [31:0] BASE      = 32'hFFFF_FF00;
    localparam logic [31:0] A_RESULT  = BASE + 32'h00;
    localparam logic [31:0] A_PASS    = BASE + 32'h04;
    localparam logic [31:0] A_FAIL    = BASE + 32'h08;
    localparam logic [31:0] A_CYCLE   = BASE + 32'h0C;
    localparam logic [31:0] A_CONSOLE = BASE + 32'h10;
    localparam logic [31:0] A_UNMAP   = BASE + 32'h14;
    localparam logic [31:0] A_OTHER   = 32'h0000_0004;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // shared driven bus
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sat_sel;

    // main instance
    logic [31:0] m_rdata;
    logic        m_rvalid, m_cv, m_done, m_passed, m_timeout;
    logic [7:0]  m_cd;

    // saturation instance
    logic [31:0] s_rdata;
    logic        s_rvalid, s_cv, s_done, s_passed, s_timeout;
    logic [7:0]  s_cd;

    test_status_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus_en    (en && !sat_sel),
        .bus_we    (we),
        .bus_addr  (addr),
        .bus_wdata (wdata),
        .bus_rdata (m_rdata),
        .bus_rvalid(m_rvalid),
        .char_valid(m_cv),
        .char_data (m_cd),
        .done      (m_done),
        .passed    (m_passed),
        .timeout   (m_timeout)
    );

    test_status_ctrl #(
        .CNT_WIDTH (2),
        .MAX_CYCLES(0)
    ) sat_dut (
        .clk       (clk),
        .rst       (rst),
        .bus_en    (en && sat_sel),
        .bus_we    (we),
        .bus_addr  (addr),
        .bus_wdata (wdata),
        .bus_rdata (s_rdata),
        .bus_rvalid(s_rvalid),
        .char_valid(s_cv),
        .char_data (s_cd),
        .done      (s_done),
        .passed    (s_passed),
        .timeout   (s_timeout)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] rdat;
    logic        rv;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1 time unit after the rising edge and
    // outputs are sampled at that same point, well away from the edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        we  = 1'b0;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        en    = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick(1);
        en    = 1'b0;
        we    = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
        en   = 1'b1;
        we   = 1'b0;
        addr = a;
        tick(1);
        en   = 1'b0;
        d    = sat_sel ? s_rdata  : m_rdata;
        v    = sat_sel ? s_rvalid : m_rvalid;
    endtask

    initial begin
        en = 1'b0; we = 1'b0; addr = '0; wdata = '0; sat_sel = 1'b0; rst = 1'b1;

        // ---------------- reset state
        do_reset();
        check("rst_rdata",   m_rdata,   32'h0);
        check("rst_rvalid",  m_rvalid,  32'h0);
        check("rst_cvalid",  m_cv,      32'h0);
        check("rst_cdata",   m_cd,      32'h0);
        check("rst_done",    m_done,    32'h0);
        check("rst_passed",  m_passed,  32'h0);
        check("rst_timeout", m_timeout, 32'h0);

        // ---------------- three passes then finish
        wr(A_RESULT, 32'h1);
        wr(A_RESULT, 32'h1);
        wr(A_RESULT, 32'h1);
        check("pre_finish_done", m_done, 32'h0);
        wr(A_RESULT, 32'h3);
        check("pass_done",    m_done,    32'h1);
        check("pass_passed",  m_passed,  32'h1);
        check("pass_timeout", m_timeout, 32'h0);
        rd(A_PASS, rdat, rv);
        check("pass_cnt_rv", rv,   32'h1);
        check("pass_cnt",    rdat, 32'h3);
        rd(A_FAIL, rdat, rv);
        check("fail_cnt0", rdat, 32'h0);
        rd(A_RESULT, rdat, rv);
        check("result_rd_done", rdat, 32'h5);
        tick(1);
        check("rvalid_drop", m_rvalid, 32'h0);
        check("rdata_zero",  m_rdata,  32'h0);

        // ---------------- pass, fail, finish
        do_reset();
        wr(A_RESULT, 32'h1);
        wr(A_RESULT, 32'h2);
        wr(A_RESULT, 32'h3);
        check("fail_done",    m_done,    32'h1);
        check("fail_passed",  m_passed,  32'h0);
        check("fail_timeout", m_timeout, 32'h0);
        rd(A_FAIL, rdat, rv);
        check("fail_cnt1", rdat, 32'h1);

        // ---------------- console, decode corners, DONE freeze
        do_reset();
        wr(A_CONSOLE, 32'h48);
        check("con1_valid", m_cv, 32'h1);
        check("con1_data",  m_cd, 32'h48);
        wr(A_CONSOLE, 32'h69);
        check("con2_valid", m_cv, 32'h1);
        check("con2_data",  m_cd, 32'h69);
        tick(1);
        check("con_pulse_end", m_cv, 32'h0);
        rd(A_UNMAP, rdat, rv);
        check("unmap_rv",   rv,   32'h1);
        check("unmap_data", rdat, 32'h0);
        rd(A_OTHER, rdat, rv);
        check("unsel_rv", rv, 32'h0);
        wr(A_PASS, 32'h7);
        wr(A_RESULT, 32'h1);
        rd(A_PASS, rdat, rv);
        check("ro_write_ignored", rdat, 32'h1);
        wr(A_RESULT, 32'h3);
        wr(A_CONSOLE, 32'h55);
        check("done_con_nopulse", m_cv, 32'h0);
        wr(A_RESULT, 32'h1);
        wr(A_RESULT, 32'h2);
        rd(A_PASS, rdat, rv);
        check("done_pass_frozen", rdat, 32'h1);
        rd(A_FAIL, rdat, rv);
        check("done_fail_frozen", rdat, 32'h0);
        check("done_passed_hold", m_passed, 32'h1);

        // ---------------- reset out of DONE
        do_reset();
        wr(A_RESULT, 32'h2);
        wr(A_RESULT, 32'h2);
        wr(A_RESULT, 32'h3);
        rd(A_FAIL, rdat, rv);
        check("fail_cnt2", rdat, 32'h2);
        check("done_before_rst", m_done, 32'h1);
        do_reset();
        check("rst2_done",    m_done,    32'h0);
        check("rst2_passed",  m_passed,  32'h0);
        check("rst2_timeout", m_timeout, 32'h0);
        check("rst2_cvalid",  m_cv,      32'h0);
        check("rst2_rvalid",  m_rvalid,  32'h0);
        rd(A_CYCLE, rdat, rv);
        check("cycle_restart", rdat, 32'h0);
        rd(A_FAIL, rdat, rv);
        check("rst2_fail_cnt", rdat, 32'h0);
        rd(A_CYCLE, rdat, rv);
        check("cycle_cnt2", rdat, 32'h2);

        // ---------------- watchdog expiry
        do_reset();
        tick(255);
        check("wd_not_yet", m_done, 32'h0);
        tick(1);
        check("wd_done",    m_done,    32'h1);
        check("wd_timeout", m_timeout, 32'h1);
        check("wd_passed",  m_passed,  32'h0);
        rd(A_CYCLE, rdat, rv);
        check("wd_cycle", rdat, 32'd255);
        rd(A_RESULT, rdat, rv);
        check("wd_result_rd", rdat, 32'h7);

        // ---------------- finish in the expiry cycle
        do_reset();
        tick(255);
        wr(A_RESULT, 32'h3);
        check("race_done",    m_done,    32'h1);
        check("race_timeout", m_timeout, 32'h0);
        check("race_passed",  m_passed,  32'h1);

        // ---------------- counter saturation (2-bit counters)
        sat_sel = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr(A_RESULT, 32'h1);
        end
        rd(A_PASS, rdat, rv);
        check("sat_rv",   rv,   32'h1);
        check("sat_pass", rdat, 32'h3);
        check("sat_no_wd", s_done, 32'h0);
        sat_sel = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
